branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter: DEPTH, 4, number of in-flight predictions held; power of two, 2..16.
REQ-002 Parameter: CNT_W, 16, width of the statistics counters.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: pred_valid  input  1  a prediction has been issued this cycle.
REQ-006 Port: pred_taken  input  1  the predicted direction, taken = 1, from the predictor's prediction output.
REQ-007 Port: pred_ready  output  1  the queue can accept a prediction (not full).
REQ-008 Port: resolve_valid  input  1  the oldest outstanding branch resolved this cycle.
REQ-009 Port: resolve_taken  input  1  the actual branch direction.
REQ-010 Port: result  output  1  one-cycle update strobe to the predictor.
REQ-011 Port: taken  output  1  actual direction accompanying result.
REQ-012 Port: mispredict  output  1  one-cycle strobe: the resolved direction differed from the queued prediction.
REQ-013 Port: orphan  output  1  one-cycle strobe: resolve_valid arrived with the queue empty.
REQ-014 Port: occupancy  output  $clog2(DEPTH)+1  number of queued predictions.
REQ-015 Port: n_resolved, n_mispred  output  CNT_W each  statistics counters; present only under BRU_STATS_EN.

Function
REQ-016 Predictions SHALL be held in a FIFO in issue order; a push occurs when pred_valid && pred_ready.
REQ-017 pred_ready SHALL be combinational: occupancy != DEPTH.
REQ-018 On resolve_valid with a non-empty queue, the head SHALL pop in that cycle.
REQ-019 result SHALL assert in the following cycle, for exactly one cycle; taken SHALL equal the registered resolve_taken in that cycle.
REQ-020 mispredict SHALL assert in the same cycle as result when the popped pred_taken != resolve_taken.
REQ-021 A mispredict SHALL flush the whole queue (occupancy to 0) on the same edge as the pop.
REQ-022 A push in the same cycle as a mispredicting pop SHALL be dropped; flush wins.
REQ-023 A push in the same cycle as a correct pop SHALL be accepted; occupancy is unchanged, including when the queue is full.
REQ-024 resolve_valid with an empty queue SHALL pulse orphan the next cycle; result, mispredict and the queue are unaffected, and a same-cycle push is accepted.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow.
REQ-026 result and taken SHALL be registered outputs; no combinational path from resolve inputs to them.

Reset
REQ-027 While rst is high: occupancy = 0, result = 0, taken = 0, mispredict = 0, orphan = 0, and counters = 0.
REQ-028 Reset asserted mid-operation SHALL discard all queued predictions and any pending strobes; no result pulse follows reset deassertion.

Configuration
REQ-029 With BRU_STATS_EN defined: n_resolved increments on every result pulse and n_mispred on every mispredict pulse; both saturate at all-ones.
REQ-030 Without BRU_STATS_EN: the counter ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package bru_pkg SHALL hold DEPTH_DEFAULT, CNT_W_DEFAULT and the queue-entry typedef (1-bit pred_taken; widened later for PC/history).
REQ-032 Queue storage and pointers SHALL be a sub-module bru_fifo, with push, pop, flush, full, empty and count ports; the top holds resolve/compare/strobe logic.

Verification
REQ-033 Push taken, taken, not-taken; resolve taken, taken, not-taken -> three result pulses with taken = 1, 1, 0; no mispredict; occupancy returns to 0.
REQ-034 Push taken x3; resolve not-taken -> result = 1, taken = 0, mispredict = 1 in the next cycle; occupancy 3 -> 0; n_mispred = 1.
REQ-035 Fill to DEPTH = 4 -> pred_ready = 0 and a further push is ignored; then same-cycle push and correct resolve -> occupancy stays 4 and the new entry sits at the tail.
REQ-036 Empty queue with resolve_valid = 1 -> orphan pulses one cycle, result stays 0; a same-cycle push yields occupancy 1.
REQ-037 Mispredicting resolve with simultaneous push -> occupancy 0 afterwards; the next resolve raises orphan.
REQ-038 Assert rst with 2 entries queued and a resolve in the same cycle -> no result pulse, occupancy 0, counters 0; run 20 correct resolves after reset -> n_resolved = 20.

Source files
------------

// File: rtl/bru_pkg.sv
// bru_pkg: shared defaults and queue-entry type for the branch resolve unit
package bru_pkg;
    localparam int DEPTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 16;
    // Single field for now; PC and history bits will be added here later
    typedef struct packed {
        logic pred_taken;
    } bru_entry_t;
endpackage

// File: rtl/bru_fifo.sv
// bru_fifo: in-order prediction queue with flush; pointers wrap modulo DEPTH.
module bru_fifo import bru_pkg::*; #(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  bru_entry_t               din,
    input  logic                     pop,
    input  logic                     flush,
    output bru_entry_t               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    bru_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    always_comb begin
        full     = count_q == CW'(DEPTH);
        empty    = count_q == '0;
        do_pop   = pop && !empty;
        // A full queue still takes a push when the head leaves on the same edge
        do_push  = push && !flush && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + AW'(do_pop);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: matches resolved branches against queued predictions.
// Statistics counters n_resolved/n_mispred exist only when BRU_STATS_EN is defined.
module branch_resolve_unit import bru_pkg::*; #(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    input  logic                   pred_taken,
    output logic                   pred_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   result,
    output logic                   taken,
    output logic                   mispredict,
    output logic                   orphan,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0]       n_resolved,
    output logic [CNT_W-1:0]       n_mispred
`endif
);
    bru_entry_t head, din;
    logic       full, empty, pop;
    logic       result_q, result_d, taken_q, taken_d;
    logic       mispredict_q, mispredict_d, orphan_q, orphan_d;
    always_comb begin
        din          = '{pred_taken: pred_taken};
        pop          = resolve_valid && !empty;
        mispredict_d = pop && (head.pred_taken != resolve_taken);
        result_d     = pop;
        taken_d      = pop && resolve_taken;
        orphan_d     = resolve_valid && empty;
    end
    // A mispredict flushes on the pop edge and swallows any same-cycle push
    bru_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pred_valid),
        .din   (din),
        .pop   (pop),
        .flush (mispredict_d),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );
    assign pred_ready = !full;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q     <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            orphan_q     <= 1'b0;
        end else begin
            result_q     <= result_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            orphan_q     <= orphan_d;
        end
    end
    assign result     = result_q;
    assign taken      = taken_q;
    assign mispredict = mispredict_q;
    assign orphan     = orphan_q;
`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] n_resolved_q, n_resolved_d, n_mispred_q, n_mispred_d;
    always_comb begin
        n_resolved_d = (result_q && ~&n_resolved_q) ? n_resolved_q + 1'b1 : n_resolved_q;
        n_mispred_d  = (mispredict_q && ~&n_mispred_q) ? n_mispred_q + 1'b1 : n_mispred_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_resolved_q <= '0;
            n_mispred_q  <= '0;
        end else begin
            n_resolved_q <= n_resolved_d;
            n_mispred_q  <= n_mispred_d;
        end
    end
    assign n_resolved = n_resolved_q;
    assign n_mispred  = n_mispred_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pred_valid = 1'b0, pred_taken = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic pred_ready, result, taken, mispredict, orphan;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] n_resolved, n_mispred;
`endif
    int checks = 0;
    int failures = 0;
    bit q[$];
    bit e_result = 0, e_taken = 0, e_mis = 0, e_orphan = 0;
    int m_res = 0, m_mis = 0;
    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .result        (result),
        .taken         (taken),
        .mispredict    (mispredict),
        .orphan        (orphan),
        .occupancy     (occupancy)
`ifdef BRU_STATS_EN
        ,
        .n_resolved    (n_resolved),
        .n_mispred     (n_mispred)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic check_outs();
        chk("result", {31'b0, result}, {31'b0, e_result});
        if (e_result) chk("taken", {31'b0, taken}, {31'b0, e_taken});
        chk("mispredict", {31'b0, mispredict}, {31'b0, e_mis});
        chk("orphan", {31'b0, orphan}, {31'b0, e_orphan});
        chk("occupancy", 32'(occupancy), q.size());
`ifdef BRU_STATS_EN
        chk("n_resolved", 32'(n_resolved), m_res);
        chk("n_mispred", 32'(n_mispred), m_mis);
`endif
    endtask
    // One clock: drive at negedge, model the edge, check just after it
    task automatic cycle(input bit pv, input bit pt, input bit rv, input bit rt);
        bit pop, mis, acc;
        pred_valid = pv; pred_taken = pt; resolve_valid = rv; resolve_taken = rt;
        #1 chk("pred_ready", {31'b0, pred_ready}, {31'b0, q.size() != DEPTH});
        @(posedge clk);
        if (e_result && m_res < (1 << CNT_W) - 1) m_res++;
        if (e_mis && m_mis < (1 << CNT_W) - 1) m_mis++;
        pop = rv && q.size() > 0;
        mis = pop && q[0] != rt;
        acc = pv && !mis && (q.size() < DEPTH || pop);
        e_result = pop; e_taken = rt; e_mis = mis; e_orphan = rv && q.size() == 0;
        if (pop) void'(q.pop_front());
        if (mis) q.delete();
        if (acc) q.push_back(pt);
        #1 check_outs();
        @(negedge clk);
    endtask
    task automatic reset_all();
        rst = 1'b1;
        #1;
        q.delete(); e_result = 0; e_mis = 0; e_orphan = 0; m_res = 0; m_mis = 0;
        check_outs();
        @(posedge clk);
        #1 check_outs();
        @(negedge clk);
        rst = 1'b0;
        pred_valid = 0; resolve_valid = 0;
    endtask
    initial begin
        @(negedge clk);
        reset_all();
        cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 1); cycle(0, 0, 1, 1); cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        chk("seq_empty", 32'(occupancy), 0);
        cycle(1, 1, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
        chk("pre_mis_occ", 32'(occupancy), 3);
        cycle(0, 0, 1, 0);
        chk("mis_pulse", {31'b0, mispredict}, 1);
        chk("mis_occ", 32'(occupancy), 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        chk("full_ready", {31'b0, pred_ready}, 0);
        cycle(1, 1, 0, 0);
        chk("full_occ", 32'(occupancy), 4);
        cycle(1, 0, 1, 1);
        chk("full_swap_occ", 32'(occupancy), 4);
        cycle(0, 0, 1, 1); cycle(0, 0, 1, 1); cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 0);
        chk("tail_no_mis", {31'b0, mispredict}, 0);
        cycle(1, 1, 1, 0);
        chk("orphan_pulse", {31'b0, orphan}, 1);
        chk("orphan_occ", 32'(occupancy), 1);
        cycle(1, 0, 1, 0);
        chk("flush_push_occ", 32'(occupancy), 0);
        cycle(0, 0, 1, 1);
        chk("flush_orphan", {31'b0, orphan}, 1);
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        pred_valid = 0; resolve_valid = 1; resolve_taken = 1;
        reset_all();
        cycle(0, 0, 0, 0);
        chk("post_rst_result", {31'b0, result}, 0);
        for (int i = 0; i < 20; i++) begin
            bit d = 1'($urandom);
            cycle(1, d, 0, 0);
            cycle(0, 0, 1, d);
        end
        cycle(0, 0, 0, 0);
`ifdef BRU_STATS_EN
        chk("n_resolved_20", 32'(n_resolved), 20);
`endif
        for (int i = 0; i < 600; i++) begin
            bit rv = ($urandom % 3) == 0;
            bit rt = (q.size() > 0 && ($urandom % 5) != 0) ? q[0] : 1'($urandom);
            cycle(($urandom % 4) != 0, 1'($urandom), rv, rt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
